branch_resolve_predict: RTL and testbench
=========================================

BRANCH_RESOLVE_PREDICT -- requirements
Module: branch_resolve_predict

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and PC width.
REQ-002 SHALL have parameter BHT_DEPTH, default 16: number of branch-history entries; must be a power of 2 and at least 2.
REQ-003 SHALL have parameter STAT_W, default 16: statistics counter width.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port if_pc, input, WIDTH bits: fetch-stage PC for the prediction lookup.
REQ-007 SHALL have port if_pred_taken, output, 1 bit: predicted direction for if_pc.
REQ-008 SHALL have port ex_valid, input, 1 bit: EX stage holds a real instruction.
REQ-009 SHALL have port ex_stall, input, 1 bit: EX is frozen this cycle.
REQ-010 SHALL have port ex_pc, input, WIDTH bits: PC of the EX instruction.
REQ-011 SHALL have port ex_br_type, input, 3 bits: branch type encoding.
REQ-012 SHALL have ports ex_val1 and ex_reg2, input, WIDTH bits each: compare operands.
REQ-013 SHALL have port ex_pred_taken, input, 1 bit: prediction carried down the pipeline with the instruction.
REQ-014 SHALL have port br_taken, output, 1 bit: resolved direction, combinational.
REQ-015 SHALL have port flush, output, 1 bit: registered misprediction pulse.
REQ-016 SHALL have port flush_taken, output, 1 bit: registered correct direction that accompanies flush.
REQ-017 SHALL have port stat_clr, input, 1 bit: synchronous clear of both statistics counters.
REQ-018 SHALL have ports stat_branches and stat_mispredicts, output, STAT_W bits each.

Function
REQ-019 SHALL decode ex_br_type as follows; each type resolves taken when its condition holds:
  - 0 NONE: never taken
  - 1 BEZ: val1 == 0
  - 2 BNE: val1 != reg2
  - 3 JMP: always taken
  - 4 BEQ: val1 == reg2
  - 5 BLTZ: signed val1 < 0
  - 6 BGEZ: signed val1 >= 0
  - 7: reserved, never taken
REQ-020 SHALL drive br_taken as the REQ-019 result whenever ex_valid=1, and 0 when ex_valid=0.
REQ-021 SHALL hold a BHT of BHT_DEPTH 2-bit saturating counters, indexed by pc[log2(BHT_DEPTH)+1:2].
REQ-022 SHALL drive if_pred_taken as the MSB of the counter at if_pc's index, combinationally.
REQ-023 SHALL treat a cycle as a resolve cycle when ex_valid=1, ex_stall=0 and flush=0.
REQ-024 SHALL, on a resolve cycle with a conditional type (1, 2, 4, 5, 6), increment the indexed counter when taken and decrement it when not taken, saturating at 3 and 0.
REQ-025 SHALL leave the BHT unchanged for types 0, 3 and 7.
REQ-026 SHALL, on a resolve cycle where br_taken != ex_pred_taken, set flush=1 and flush_taken=br_taken in the next cycle; flush is a one-cycle pulse.
REQ-027 SHALL ignore all EX inputs while flush=1 (wrong-path slot): no BHT update, no stats update, no new flush.
REQ-028 SHALL, when the IF lookup and an EX update hit the same index in the same cycle, return the pre-update value on if_pred_taken (no bypass).
REQ-029 SHALL increment stat_branches on every resolve cycle with type 1-6.
REQ-030 SHALL increment stat_mispredicts on every resolve cycle that raises flush.
REQ-031 SHALL saturate both statistics counters at all-ones.
REQ-032 SHALL give stat_clr priority over a same-cycle increment.
REQ-033 SHALL complete a misprediction as a flush response with latency exactly 1 cycle after the resolve edge.

Reset
REQ-034 SHALL, while rst_n=0, immediately force all BHT counters to 2'b01 (weakly not taken), flush=0, flush_taken=0, stat_branches=0 and stat_mispredicts=0.
REQ-035 SHALL, when reset is asserted mid-flush, drop flush immediately; the first edge after release is a normal resolve cycle.

Structure
REQ-036 SHALL take the branch-type encodings (REQ-019) and the BHT reset value from the shared package mips_branch_pkg.
REQ-037 SHALL implement the REQ-019 evaluation in the combinational sub-module br_cond_eval, which has no state.

Verification
REQ-038 SHALL cover: after reset, if_pc=0x40 -> if_pred_taken=0; then type 1 at pc 0x40 with val1=0, pred 0, twice (flush-slot gap between) -> counter reaches 3, if_pred_taken=1.
REQ-039 SHALL cover: type 2, val1=5, reg2=5, pred 1 -> br_taken=0; flush=1 with flush_taken=0 next cycle; the EX input presented during the flush cycle is ignored; stat_mispredicts=1.
REQ-040 SHALL cover: type 5, val1=0x80000000 -> taken; val1=0 -> not taken; type 6, val1=0 -> taken.
REQ-041 SHALL cover: type 3 with pred 0 -> flush with flush_taken=1, BHT unchanged, stat_branches+1.
REQ-042 SHALL cover: ex_stall=1 with a mispredicting branch -> no flush, no update; stat_clr coinciding with a counted branch -> stats=0.
REQ-043 SHALL cover: STAT_W=2 -> stat_branches saturates at 3 after 5 branches; rst_n pulled low asynchronously mid-flush -> flush=0 without waiting for a clock edge.

Source files
------------

// File: rtl/mips_branch_pkg.sv
// Shared branch-type encodings and BHT constants for the EX-stage branch resolver
// and its direction predictor.
package mips_branch_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEZ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_JMP  = 3'd3,
    BR_BEQ  = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6,
    BR_RSVD = 3'd7
  } br_type_e;

  // Weakly not-taken, so a cold entry flips to taken after one taken outcome.
  localparam logic [1:0] BHT_RESET_VAL = 2'b01;

  function automatic logic is_conditional(input logic [2:0] t);
    case (t)
      BR_BEZ, BR_BNE, BR_BEQ, BR_BLTZ, BR_BGEZ: is_conditional = 1'b1;
      default:                                  is_conditional = 1'b0;
    endcase
  endfunction

  function automatic logic is_counted_branch(input logic [2:0] t);
    is_counted_branch = (t != BR_NONE) && (t != BR_RSVD);
  endfunction

  function automatic logic [1:0] sat2_next(input logic [1:0] ctr, input logic up);
    if (up) sat2_next = (ctr == 2'b11) ? ctr : ctr + 2'b01;
    else    sat2_next = (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Stateless branch-condition evaluator: decodes the branch type and compares
// the two EX operands.
module br_cond_eval
  import mips_branch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       br_type,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] reg2,
  output logic             cond_taken
);

  always_comb begin
    cond_taken = 1'b0;
    case (br_type)
      BR_BEZ:  cond_taken = (val1 == '0);
      BR_BNE:  cond_taken = (val1 != reg2);
      BR_JMP:  cond_taken = 1'b1;
      BR_BEQ:  cond_taken = (val1 == reg2);
      BR_BLTZ: cond_taken = val1[WIDTH-1];
      BR_BGEZ: cond_taken = ~val1[WIDTH-1];
      default: cond_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_predict.sv
// EX-stage branch resolution with a 2-bit bimodal predictor for IF, a registered
// misprediction flush and saturating branch statistics.
module branch_resolve_predict
  import mips_branch_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BHT_DEPTH = 16,
  parameter int STAT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  if_pc,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic              ex_stall,
  input  logic [WIDTH-1:0]  ex_pc,
  input  logic [2:0]        ex_br_type,
  input  logic [WIDTH-1:0]  ex_val1,
  input  logic [WIDTH-1:0]  ex_reg2,
  input  logic              ex_pred_taken,
  output logic              br_taken,
  output logic              flush,
  output logic              flush_taken,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]        bht_q [BHT_DEPTH];
  logic              flush_q, flush_d;
  logic              flush_taken_q, flush_taken_d;
  logic [STAT_W-1:0] br_cnt_q, br_cnt_d;
  logic [STAT_W-1:0] mp_cnt_q, mp_cnt_d;

  logic [IDX_W-1:0]  if_idx, ex_idx;
  logic              cond_taken;
  logic              resolve, mispredict, bht_upd, count_br;
  logic [1:0]        ctr_next;
  logic              unused_pc_bits;

  br_cond_eval #(.WIDTH(WIDTH)) u_cond (
    .br_type    (ex_br_type),
    .val1       (ex_val1),
    .reg2       (ex_reg2),
    .cond_taken (cond_taken)
  );

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{if_pc[WIDTH-1:IDX_W+2], if_pc[1:0],
                            ex_pc[WIDTH-1:IDX_W+2], ex_pc[1:0]};

  assign br_taken      = ex_valid & cond_taken;
  // Read straight from the array: a same-cycle update is not forwarded.
  assign if_pred_taken = bht_q[if_idx][1];

  // The slot right after a flush holds a wrong-path instruction, so it never resolves.
  assign resolve    = ex_valid & ~ex_stall & ~flush_q;
  assign mispredict = resolve & (br_taken != ex_pred_taken);
  assign bht_upd    = resolve & is_conditional(ex_br_type);
  assign count_br   = resolve & is_counted_branch(ex_br_type);
  assign ctr_next   = sat2_next(bht_q[ex_idx], br_taken);

  always_comb begin
    flush_d       = mispredict;
    flush_taken_d = mispredict & br_taken;
    br_cnt_d      = br_cnt_q;
    mp_cnt_d      = mp_cnt_q;
    if (stat_clr) begin
      br_cnt_d = '0;
      mp_cnt_d = '0;
    end else begin
      if (count_br && !(&br_cnt_q))   br_cnt_d = br_cnt_q + STAT_W'(1);
      if (mispredict && !(&mp_cnt_q)) mp_cnt_d = mp_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= BHT_RESET_VAL;
    end else if (bht_upd) begin
      bht_q[ex_idx] <= ctr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q       <= 1'b0;
      flush_taken_q <= 1'b0;
      br_cnt_q      <= '0;
      mp_cnt_q      <= '0;
    end else begin
      flush_q       <= flush_d;
      flush_taken_q <= flush_taken_d;
      br_cnt_q      <= br_cnt_d;
      mp_cnt_q      <= mp_cnt_d;
    end
  end

  assign flush            = flush_q;
  assign flush_taken      = flush_taken_q;
  assign stat_branches    = br_cnt_q;
  assign stat_mispredicts = mp_cnt_q;

endmodule

// File: tb/tb_branch_resolve_predict.sv
// Scoreboard bench: the driver pushes one expected record per cycle from a
// behavioural model; the monitor pops and compares on every falling edge.
module tb_branch_resolve_predict;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] if_pc = 32'h0;
  logic        ex_valid = 1'b0, ex_stall = 1'b0, ex_pred_taken = 1'b0, stat_clr = 1'b0;
  logic [31:0] ex_pc = 32'h0, ex_val1 = 32'h0, ex_reg2 = 32'h0;
  logic [2:0]  ex_br_type = 3'd0;

  logic        if_pred_taken, br_taken, flush, flush_taken;
  logic [15:0] stat_branches, stat_mispredicts;
  logic        if_pred2, br2, flush2, ft2;
  logic [1:0]  stat_b2, stat_m2;

  always #5 clk = ~clk;

  branch_resolve_predict #(.WIDTH(32), .BHT_DEPTH(16), .STAT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_pc(ex_pc), .ex_br_type(ex_br_type),
    .ex_val1(ex_val1), .ex_reg2(ex_reg2), .ex_pred_taken(ex_pred_taken),
    .br_taken(br_taken), .flush(flush), .flush_taken(flush_taken), .stat_clr(stat_clr),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  branch_resolve_predict #(.WIDTH(32), .BHT_DEPTH(16), .STAT_W(2)) dut_s2 (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred2),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_pc(ex_pc), .ex_br_type(ex_br_type),
    .ex_val1(ex_val1), .ex_reg2(ex_reg2), .ex_pred_taken(ex_pred_taken),
    .br_taken(br2), .flush(flush2), .flush_taken(ft2), .stat_clr(stat_clr),
    .stat_branches(stat_b2), .stat_mispredicts(stat_m2)
  );

  typedef struct {
    bit in_rst, fl, ft, br, pr;
    int sb, sm, sb2, sm2;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: the predictor table as plain integers 0..3.
  int m_bht[16];
  bit m_flush, m_ft;
  int m_sb, m_sm, m_sb2, m_sm2;

  function automatic int sat_inc(int v, int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  task automatic model_step(input bit rv, input bit v, input bit st, input logic [31:0] pc,
                            input logic [2:0] t, input logic [31:0] a, input logic [31:0] b,
                            input bit p, input bit clr, input logic [31:0] ipc,
                            output exp_t e);
    bit cond, br, res, nf;
    int idx;
    if (!rv) begin
      for (int i = 0; i < 16; i++) m_bht[i] = 1;
      m_flush = 0; m_ft = 0; m_sb = 0; m_sm = 0; m_sb2 = 0; m_sm2 = 0;
    end
    case (t)
      3'd1: cond = (a == 0);
      3'd2: cond = (a != b);
      3'd3: cond = 1;
      3'd4: cond = (a == b);
      3'd5: cond = ($signed(a) < 0);
      3'd6: cond = ($signed(a) >= 0);
      default: cond = 0;
    endcase
    br = v && cond;
    e.in_rst = !rv; e.fl = m_flush; e.ft = m_ft; e.br = br;
    e.pr = (m_bht[(ipc >> 2) % 16] >= 2);
    e.sb = m_sb; e.sm = m_sm; e.sb2 = m_sb2; e.sm2 = m_sm2;
    if (rv) begin
      res = v && !st && !m_flush;
      nf  = res && (br != p);
      idx = (pc >> 2) % 16;
      if (res && (t == 1 || t == 2 || t == 4 || t == 5 || t == 6))
        m_bht[idx] = br ? ((m_bht[idx] == 3) ? 3 : m_bht[idx] + 1)
                        : ((m_bht[idx] == 0) ? 0 : m_bht[idx] - 1);
      if (clr) begin
        m_sb = 0; m_sm = 0; m_sb2 = 0; m_sm2 = 0;
      end else begin
        if (res && t >= 1 && t <= 6) begin
          m_sb = sat_inc(m_sb, 65535); m_sb2 = sat_inc(m_sb2, 3);
        end
        if (nf) begin
          m_sm = sat_inc(m_sm, 65535); m_sm2 = sat_inc(m_sm2, 3);
        end
      end
      m_flush = nf;
      m_ft    = nf && br;
    end
  endtask

  task automatic cyc(input bit v, input bit st, input logic [31:0] pc, input logic [2:0] t,
                     input logic [31:0] a, input logic [31:0] b, input bit p, input bit clr,
                     input logic [31:0] ipc, input bit rv, input bit async_drop);
    exp_t e;
    @(posedge clk);
    #1;
    ex_valid = v; ex_stall = st; ex_pc = pc; ex_br_type = t; ex_val1 = a; ex_reg2 = b;
    ex_pred_taken = p; stat_clr = clr; if_pc = ipc;
    if (!async_drop) rst_n = rv;
    model_step(rv && !async_drop, v, st, pc, t, a, b, p, clr, ipc, e);
    q.push_back(e);
    // Pull reset low between clock edges while the previous edge raised flush.
    if (async_drop) begin
      #1;
      rst_n = 1'b0;
    end
  endtask

  task automatic idle(input logic [31:0] ipc);
    cyc(0, 0, 32'h0, 3'd0, 32'h0, 32'h0, 0, 0, ipc, 1, 0);
  endtask

  task automatic chk(input string nm, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("br_taken", int'(br_taken), int'(e.br));
        chk("if_pred_taken", int'(if_pred_taken), int'(e.pr));
        chk("flush", int'(flush), int'(e.fl));
        if (e.fl || e.in_rst) chk("flush_taken", int'(flush_taken), int'(e.ft));
        chk("stat_branches", int'(stat_branches), e.sb);
        chk("stat_mispredicts", int'(stat_mispredicts), e.sm);
        chk("stat_branches_w2", int'(stat_b2), e.sb2);
        chk("stat_mispredicts_w2", int'(stat_m2), e.sm2);
      end
    end
  end

  initial begin : driver
    logic [31:0] pc, ipc, a, b;
    logic [2:0]  t;
    // Reset, then train pc 0x40 with two taken BEZ outcomes.
    cyc(0, 0, 32'h0, 3'd0, 0, 0, 0, 0, 32'h40, 0, 0);
    cyc(0, 0, 32'h0, 3'd0, 0, 0, 0, 0, 32'h40, 0, 0);
    cyc(1, 0, 32'h40, 3'd1, 0, 0, 0, 0, 32'h40, 1, 0);
    cyc(1, 0, 32'h40, 3'd1, 0, 0, 0, 0, 32'h40, 1, 0);
    cyc(1, 0, 32'h40, 3'd1, 0, 0, 0, 0, 32'h40, 1, 0);
    idle(32'h40);
    idle(32'h40);
    // BNE equal operands with wrong prediction; flush slot carries a bogus branch.
    cyc(1, 0, 32'h80, 3'd2, 5, 5, 1, 0, 32'h80, 1, 0);
    cyc(1, 0, 32'h84, 3'd4, 1, 2, 1, 0, 32'h84, 1, 0);
    idle(32'h80);
    // Sign tests with correct predictions.
    cyc(1, 0, 32'h90, 3'd5, 32'h8000_0000, 0, 1, 0, 32'h90, 1, 0);
    cyc(1, 0, 32'h90, 3'd5, 32'h0, 0, 0, 0, 32'h90, 1, 0);
    cyc(1, 0, 32'h94, 3'd6, 32'h0, 0, 1, 0, 32'h94, 1, 0);
    // Unconditional jump mispredicted: no BHT change at 0x44.
    cyc(1, 0, 32'h44, 3'd3, 0, 0, 0, 0, 32'h44, 1, 0);
    idle(32'h44);
    // Stalled mispredicting branch, then stat_clr against a counted branch.
    cyc(1, 1, 32'h48, 3'd2, 1, 2, 0, 0, 32'h48, 1, 0);
    idle(32'h48);
    cyc(1, 0, 32'h4c, 3'd4, 7, 7, 1, 1, 32'h4c, 1, 0);
    idle(32'h4c);
    // Five correctly predicted branches saturate the narrow counter.
    for (int i = 0; i < 5; i++) cyc(1, 0, 32'h50, 3'd3, 0, 0, 1, 0, 32'h50, 1, 0);
    idle(32'h50);
    // Mispredict, then asynchronous reset during the flush cycle.
    cyc(1, 0, 32'h60, 3'd3, 0, 0, 0, 0, 32'h60, 1, 0);
    cyc(1, 0, 32'h60, 3'd3, 0, 0, 0, 0, 32'h60, 1, 1);
    cyc(1, 0, 32'h60, 3'd3, 0, 0, 0, 0, 32'h60, 1, 0);
    cyc(1, 0, 32'h64, 3'd1, 0, 0, 0, 0, 32'h64, 1, 0);
    idle(32'h60);
    // Randomised traffic over a small PC pool so entries alias and saturate.
    for (int i = 0; i < 3000; i++) begin
      pc  = 32'($urandom_range(0, 63)) << 2;
      ipc = ($urandom_range(0, 1) == 0) ? pc : (32'($urandom_range(0, 63)) << 2);
      t   = 3'($urandom_range(0, 7));
      b   = $urandom;
      case ($urandom_range(0, 3))
        0: a = 32'h0;
        1: a = b;
        2: a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      cyc($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 15, pc, t, a, b,
          1'($urandom_range(0, 1)), $urandom_range(0, 99) < 2, ipc,
          $urandom_range(0, 99) >= 1, 0);
    end
    idle(32'h0);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
